uart_msg_rx: RTL and testbench
==============================

UART_MSG_RX -- requirements
Module: uart_msg_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the number of clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rx  input  1  serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-005 rx_data  output  8  last correctly framed byte.
REQ-006 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-007 msg_valid  output  1  one-cycle pulse when a complete, well-formed message has been decoded.
REQ-008 node_num  output  2  decoded node digit: '1'->1, '2'->2, '3'->3.
REQ-009 colour  output  3  one-hot decoded colour letter: 'M'->3'b001, 'D'->3'b010, 'W'->3'b100.
REQ-010 msg_err  output  1  one-cycle pulse on a framing error or a parse mismatch.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all references to rx below mean the synchronized value.
REQ-012 Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE -> START on a 1->0 transition of rx; the bit counter SHALL clear.
REQ-014 START: sample rx at count CLKS_PER_BIT/2-1 (integer division).
- rx=0 -> DATA.
- rx=1 -> IDLE (false start); no error is flagged.
REQ-015 DATA: sample 8 bits, LSB first, each exactly CLKS_PER_BIT cycles after the previous sample, then go to STOP.
REQ-016 STOP: sample rx one CLKS_PER_BIT after bit 7.
- rx=1 -> load rx_data, pulse rx_valid on the next cycle, go to IDLE.
- rx=0 -> framing error: pulse msg_err, discard the byte, go to WAIT_HIGH.
REQ-017 WAIT_HIGH -> IDLE on the first cycle with rx=1.
REQ-018 Parse FSM advances only on rx_valid. It expects, in order: 'G'(0x47) 'B'(0x42) 'I'(0x49) digit('1'..'3') '-'(0x2D) letter('M','D','W') '-'(0x2D) '#'(0x23) NUL(0x00).
REQ-019 The digit and letter SHALL be captured into shadow registers; node_num and colour SHALL update only when the NUL is accepted.
REQ-020 On NUL acceptance, msg_valid and the node_num/colour update SHALL occur in the cycle after the rx_valid for that NUL. Latency from the stop-bit sample to msg_valid is 2 cycles.
REQ-021 Parse mismatch in any state:
- pulse msg_err in the cycle after rx_valid;
- if the offending byte is 'G', go to expect-'B';
- otherwise go to expect-'G'.
REQ-022 A framing error SHALL return the parse FSM to expect-'G' and discard the shadow registers.
REQ-023 node_num and colour SHALL hold their last valid values between messages; a failed message leaves them unchanged.
REQ-024 rx_valid, msg_valid and msg_err SHALL never be high for more than one consecutive cycle per event.
REQ-025 A 'G' arriving in expect-'G' while a message is already complete SHALL start a new message; there is no inter-message gap requirement beyond one stop bit.

Reset
REQ-026 On rst=1, all state SHALL clear asynchronously:
- bit FSM -> IDLE, parse FSM -> expect-'G';
- rx_data=0, rx_valid=0, msg_valid=0, msg_err=0, node_num=0, colour=0;
- synchronizer flops -> 1.
REQ-027 Reset mid-byte or mid-message SHALL abandon the byte or message silently, with no msg_err.
REQ-028 After rst deasserts, a line already low SHALL NOT start reception until a fresh 1->0 transition occurs.

Configuration
REQ-029 Macro UART_MSG_ERR_CNT_EN controls an error counter.
- Defined: adds output err_cnt[7:0], which increments on every msg_err pulse, saturates at 255 and resets to 0.
- Undefined: no err_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-030 Frames "GBI1-M-#\0" at 434 clk/bit -> 9 rx_valid pulses; then msg_valid with node_num=1, colour=3'b001; msg_err never asserted.
REQ-031 "GBI3-W-#\0" followed immediately by "GBI2-D-#\0" -> two msg_valid pulses: first node_num=3/colour=3'b100, then node_num=2/colour=3'b010.
REQ-032 0x47 sent with stop bit 0, then a valid message -> one msg_err pulse, 0 rx_valid for the bad byte, then a correct msg_valid (err_cnt=1 when UART_MSG_ERR_CNT_EN is defined).
REQ-033 "GGBI2-D-#\0" -> one msg_err on the second 'G'; resync; msg_valid with node_num=2, colour=3'b010.
REQ-034 "GBI4-M-#\0" -> msg_err after '4'; no msg_valid; node_num/colour keep their prior values.
REQ-035 rx low pulse of 100 cycles (false start) -> no rx_valid; rst asserted mid-byte -> outputs zero, no msg_err; next valid message decodes correctly.

Source files
------------

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: 8N1 UART receiver feeding a parser for "GBI<d>-<c>-#\0" node/colour messages.
// Latency: rx_valid 1 cycle after the stop-bit sample; msg_valid/msg_err 1 cycle after rx_valid.
// Backpressure: none; bytes and messages are pulsed out once and never stalled.
// Ports: clk, rst (async active-high), rx (raw serial line) ->
//        rx_data/rx_valid (byte), msg_valid/node_num/colour (message), msg_err (framing or parse error).
// Optional: define UART_MSG_ERR_CNT_EN to add err_cnt[7:0], a saturating count of msg_err pulses.
module uart_msg_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       msg_valid,
    output logic [1:0] node_num,
    output logic [2:0] colour,
    output logic       msg_err
`ifdef UART_MSG_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} bit_state_t;

    // ---------------- synchronizer and start-edge detect ----------------
    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] settle_q;
    logic       fall_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            settle_q  <= 2'd0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
        end
    end

    // The synchronizer resets to 1, so a line held low through reset would look
    // like a falling edge; edges count only once real samples fill the pipeline.
    assign fall_edge = (settle_q == 2'd3) && rx_prev_q && !rx_sync_q;

    // ---------------- bit FSM ----------------
    bit_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bit_tick, byte_ok, frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Half-bit sample in START centres every later sample in its bit cell.
    always_comb begin
        bit_tick  = 1'b0;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_START: bit_tick = (cnt_q == HALF_M1);
            S_DATA:  bit_tick = (cnt_q == FULL_M1);
            S_STOP: begin
                bit_tick  = (cnt_q == FULL_M1);
                byte_ok   = bit_tick && rx_sync_q;
                frame_err = bit_tick && !rx_sync_q;
            end
            default: bit_tick = 1'b0;
        endcase
    end

    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= byte_ok;
            if (byte_ok) rx_data_q <= shift_q;
        end
    end

    // ---------------- parse FSM ----------------
    // pidx_q is the position in "GBI<d>-<c>-#\0" currently expected (0 = 'G').
    logic [3:0] pidx_q, pidx_d;
    logic [1:0] sh_node_q, sh_node_d, node_q, node_d;
    logic [2:0] sh_col_q, sh_col_d, col_q, col_d;
    logic       msg_valid_q, msg_valid_d, msg_err_q, msg_err_d;
    logic       byte_match;
    logic [2:0] col_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pidx_q      <= 4'd0;
            sh_node_q   <= 2'd0;
            sh_col_q    <= 3'd0;
            node_q      <= 2'd0;
            col_q       <= 3'd0;
            msg_valid_q <= 1'b0;
            msg_err_q   <= 1'b0;
        end else begin
            pidx_q      <= pidx_d;
            sh_node_q   <= sh_node_d;
            sh_col_q    <= sh_col_d;
            node_q      <= node_d;
            col_q       <= col_d;
            msg_valid_q <= msg_valid_d;
            msg_err_q   <= msg_err_d;
        end
    end

    always_comb begin
        pidx_d      = pidx_q;
        sh_node_d   = sh_node_q;
        sh_col_d    = sh_col_q;
        node_d      = node_q;
        col_d       = col_q;
        msg_valid_d = 1'b0;
        msg_err_d   = frame_err;
        if (frame_err) begin
            pidx_d    = 4'd0;
            sh_node_d = 2'd0;
            sh_col_d  = 3'd0;
        end else if (rx_valid_q) begin
            if (byte_match) begin
                if (pidx_q == 4'd8) begin
                    node_d      = sh_node_q;
                    col_d       = sh_col_q;
                    msg_valid_d = 1'b1;
                    pidx_d      = 4'd0;
                end else begin
                    if (pidx_q == 4'd3) sh_node_d = rx_data_q[1:0];
                    if (pidx_q == 4'd5) sh_col_d  = col_val;
                    pidx_d = pidx_q + 4'd1;
                end
            end else begin
                msg_err_d = 1'b1;
                // A stray 'G' is itself a valid message start.
                pidx_d    = (rx_data_q == 8'h47) ? 4'd1 : 4'd0;
            end
        end
    end

    always_comb begin
        col_val = 3'b000;
        case (rx_data_q)
            8'h4D:   col_val = 3'b001;
            8'h44:   col_val = 3'b010;
            8'h57:   col_val = 3'b100;
            default: col_val = 3'b000;
        endcase
        case (pidx_q)
            4'd0:    byte_match = (rx_data_q == 8'h47);
            4'd1:    byte_match = (rx_data_q == 8'h42);
            4'd2:    byte_match = (rx_data_q == 8'h49);
            4'd3:    byte_match = (rx_data_q >= 8'h31) && (rx_data_q <= 8'h33);
            4'd4:    byte_match = (rx_data_q == 8'h2D);
            4'd5:    byte_match = (col_val != 3'b000);
            4'd6:    byte_match = (rx_data_q == 8'h2D);
            4'd7:    byte_match = (rx_data_q == 8'h23);
            4'd8:    byte_match = (rx_data_q == 8'h00);
            default: byte_match = 1'b0;
        endcase
    end

`ifdef UART_MSG_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                err_cnt_q <= 8'd0;
        else if (msg_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign msg_valid = msg_valid_q;
    assign msg_err   = msg_err_q;
    assign node_num  = node_q;
    assign colour    = col_q;

endmodule

// File: tb/tb_uart_msg_rx.sv
`timescale 1ns/1ps
module tb_uart_msg_rx;

    localparam int CPB = 20;
    localparam int K_RXV = 0, K_ERR = 1, K_MSG = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid, msg_valid, msg_err;
    logic [1:0] node_num;
    logic [2:0] colour;
`ifdef UART_MSG_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    uart_msg_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .msg_valid (msg_valid),
        .node_num  (node_num),
        .colour    (colour),
        .msg_err   (msg_err)
`ifdef UART_MSG_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [1:0] node;
        logic [2:0] col;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    // Reference model state: position in the message template, captured fields,
    // and the node/colour the outputs should be holding.
    int         m_pos = 0;
    logic [1:0] m_shn = 0, m_node = 0;
    logic [2:0] m_shc = 0, m_col = 0;
    int         m_errs = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    function automatic logic [2:0] col_of(logic [7:0] b);
        string letters = "MDW";
        for (int i = 0; i < 3; i++)
            if (b == letters[i]) return 3'(1 << i);
        return 3'b000;
    endfunction

    function automatic bit tmpl_ok(int pos, logic [7:0] b);
        string t = "GBI?-?-#";
        if (pos == 8) return b == 8'h00;
        if (pos == 3) return (b >= "1") && (b <= "3");
        if (pos == 5) return col_of(b) != 3'b000;
        return b == t[pos];
    endfunction

    task automatic push_ev(int kind, logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.node = m_node;
        e.col  = m_col;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(logic [7:0] b, bit stop_ok);
        if (!stop_ok) begin
            push_ev(K_ERR, 8'h00);
            m_errs++;
            m_pos = 0;
            m_shn = 0;
            m_shc = 0;
            return;
        end
        push_ev(K_RXV, b);
        if (tmpl_ok(m_pos, b)) begin
            if (m_pos == 3) m_shn = 2'(b - "0");
            if (m_pos == 5) m_shc = col_of(b);
            if (m_pos == 8) begin
                m_node = m_shn;
                m_col  = m_shc;
                push_ev(K_MSG, 8'h00);
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end else begin
            push_ev(K_ERR, 8'h00);
            m_errs++;
            m_pos = (b == "G") ? 1 : 0;
        end
    endtask

    task automatic send_bit(logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, bit stop_ok);
        model_byte(b, stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        if (!stop_ok) send_bit(1'b1);
    endtask

    task automatic send_msg(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        send_byte(8'h00, 1'b1);
    endtask

    task automatic drain(string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_pending_events"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({nm, "_node_hold"}, 32'(node_num), 32'(m_node));
        check({nm, "_colour_hold"}, 32'(colour), 32'(m_col));
`ifdef UART_MSG_ERR_CNT_EN
        check({nm, "_err_cnt"}, 32'(err_cnt), 32'((m_errs > 255) ? 255 : m_errs));
`endif
    endtask

    task automatic reset_checks(string nm);
        check({nm, "_rx_data"}, 32'(rx_data), 32'd0);
        check({nm, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({nm, "_msg_valid"}, 32'(msg_valid), 32'd0);
        check({nm, "_msg_err"}, 32'(msg_err), 32'd0);
        check({nm, "_node_num"}, 32'(node_num), 32'd0);
        check({nm, "_colour"}, 32'(colour), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic p_rxv = 1'b0, p_err = 1'b0, p_msg = 1'b0;

    task automatic pop_check(int kind, string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_%s: got pulse, expected none (t=%0t)", nm, $time);
            return;
        end
        e = exp_q.pop_front();
        check({nm, "_kind"}, 32'(kind), 32'(e.kind));
        if (e.kind == K_RXV && kind == K_RXV) check("rx_data", 32'(rx_data), 32'(e.data));
        check({nm, "_node_num"}, 32'(node_num), 32'(e.node));
        check({nm, "_colour"}, 32'(colour), 32'(e.col));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p_rxv <= 1'b0;
            p_err <= 1'b0;
            p_msg <= 1'b0;
        end else begin
            if (rx_valid) begin
                check("rx_valid_single_cycle", 32'(p_rxv), 32'd0);
                pop_check(K_RXV, "rx_valid");
            end
            if (msg_err) begin
                check("msg_err_single_cycle", 32'(p_err), 32'd0);
                pop_check(K_ERR, "msg_err");
            end
            if (msg_valid) begin
                check("msg_valid_single_cycle", 32'(p_msg), 32'd0);
                pop_check(K_MSG, "msg_valid");
            end
            p_rxv <= rx_valid;
            p_err <= msg_err;
            p_msg <= msg_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] mb[9];
        string      tmpl;
        string      letters;
        int         bad;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);

        send_msg("GBI1-M-#");
        drain("single_msg");

        send_msg("GBI3-W-#");
        send_msg("GBI2-D-#");
        drain("back_to_back");

        send_byte(8'h47, 1'b0);
        send_msg("GBI1-W-#");
        drain("framing_error");

        send_msg("GGBI2-D-#");
        drain("double_g");

        send_msg("GBI4-M-#");
        drain("bad_digit");

        // Short low glitch: START samples high again and gives up silently.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        drain("false_start");
        send_msg("GBI1-D-#");
        drain("after_false_start");

        // Reset in the middle of a byte with the line held low across reset.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("mid_byte_reset");
        m_pos = 0; m_shn = 0; m_shc = 0; m_node = 0; m_col = 0; m_errs = 0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        drain("low_after_reset");
        send_msg("GBI3-D-#");
        drain("after_reset");

        // Randomized messages with occasional corrupted bytes and bad stop bits.
        tmpl    = "GBI?-?-#";
        letters = "MDW";
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i < 8; i++) mb[i] = tmpl[i];
            mb[3] = 8'(8'h30 + $urandom_range(1, 3));
            mb[5] = letters[$urandom_range(0, 2)];
            mb[8] = 8'h00;
            if ($urandom_range(0, 3) == 0) mb[$urandom_range(0, 8)] = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
            for (int i = 0; i < 9; i++) send_byte(mb[i], i != bad);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2 * CPB)) @(posedge clk);
        end
        drain("random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
